// File: rtl/hsv_core_commit_redirect.sv
// Commit stage: retires one instruction per cycle, writes back rd,
// and sequences the pipeline flush plus fetch redirect on jump/trap.
package hsv_core_pkg;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] next_pc;
    logic        jump;
    logic        trap;
    logic        writeback;
    logic [4:0]  rd;
    logic [31:0] rd_value;
  } commit_data_t;

endpackage

module hsv_core_commit_redirect
  import hsv_core_pkg::*;
#(
  parameter int          NUM_ACK     = 4,
  parameter logic [31:0] TRAP_VECTOR = 32'h0000_0100
) (
  input  logic               clk_core,
  input  logic               rst_core_n,
  input  commit_data_t       commit_data,
  input  logic               valid_i,
  output logic               ready_o,
  output logic               wr_en,
  output logic [4:0]         wr_addr,
  output logic [31:0]        wr_data,
  output logic               flush_req,
  input  logic [NUM_ACK-1:0] flush_ack,
  output logic               redirect_valid,
  output logic [31:0]        redirect_pc,
  input  logic               redirect_ready,
  output logic [63:0]        instret
);

  typedef enum logic [1:0] {
    RUN,
    FLUSH,
    REDIRECT
  } state_t;

  state_t      state;
  logic        run_en;
  logic        settle;
  logic [31:0] target;
  logic        accept;
  logic        all_ack;
  logic        do_wb;
  logic        unused_pc;

  // run_en is the released reset, synchronised to clk_core
  assign ready_o   = (state == RUN) & run_en;
  assign accept    = valid_i & ready_o;
  assign all_ack   = &flush_ack;
  assign do_wb     = commit_data.writeback
                   & (commit_data.rd != 5'd0);
  assign unused_pc = ^commit_data.pc;

  always_ff @(posedge clk_core or negedge rst_core_n) begin
    if (!rst_core_n) begin
      state          <= RUN;
      run_en         <= 1'b0;
      settle         <= 1'b0;
      target         <= '0;
      wr_en          <= 1'b0;
      wr_addr        <= '0;
      wr_data        <= '0;
      flush_req      <= 1'b0;
      redirect_valid <= 1'b0;
      redirect_pc    <= '0;
      instret        <= '0;
    end else begin
      run_en <= 1'b1;
      wr_en  <= 1'b0;
      case (state)
        RUN: begin
          if (accept) begin
            if (commit_data.trap) begin
              target    <= TRAP_VECTOR;
              state     <= FLUSH;
              flush_req <= 1'b1;
              settle    <= 1'b1;
            end else begin
              instret <= instret + 64'd1;
              if (do_wb) begin
                wr_en   <= 1'b1;
                wr_addr <= commit_data.rd;
                wr_data <= commit_data.rd_value;
              end
              if (commit_data.jump) begin
                target    <= commit_data.next_pc;
                state     <= FLUSH;
                flush_req <= 1'b1;
                settle    <= 1'b1;
              end
            end
          end
        end
        FLUSH: begin
          // acks may still be stale from a previous flush here
          if (settle) begin
            settle <= 1'b0;
          end else if (all_ack) begin
            state          <= REDIRECT;
            redirect_valid <= 1'b1;
            redirect_pc    <= target;
          end
        end
        REDIRECT: begin
          if (redirect_ready) begin
            state          <= RUN;
            flush_req      <= 1'b0;
            redirect_valid <= 1'b0;
          end
        end
        default: begin
          state <= RUN;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_hsv_core_commit_redirect.sv
// Scoreboard bench for hsv_core_commit_redirect: directed commits,
// writeback and redirect expectations checked by a negedge monitor.
module tb_hsv_core_commit_redirect;
  import hsv_core_pkg::*;

  localparam int          NA = 4;
  localparam logic [31:0] TV = 32'h0000_0100;

  logic          clk_core = 1'b0;
  logic          rst_core_n = 1'b0;
  commit_data_t  commit_data = '0;
  logic          valid_i = 1'b0;
  logic          ready_o;
  logic          wr_en;
  logic [4:0]    wr_addr;
  logic [31:0]   wr_data;
  logic          flush_req;
  logic [NA-1:0] flush_ack;
  logic          redirect_valid;
  logic [31:0]   redirect_pc;
  logic          redirect_ready = 1'b1;
  logic [63:0]   instret;

  int errs = 0;
  int checks = 0;

  logic [36:0] wb_q[$];
  logic [31:0] rd_q[$];
  logic [63:0] exp_ir = '0;

  int dly[NA] = '{1, 1, 1, 1};
  int ack_cnt;
  bit hold_acks = 1'b0;

  hsv_core_commit_redirect #(
    .NUM_ACK(NA),
    .TRAP_VECTOR(TV)
  ) dut (
    .clk_core(clk_core),
    .rst_core_n(rst_core_n),
    .commit_data(commit_data),
    .valid_i(valid_i),
    .ready_o(ready_o),
    .wr_en(wr_en),
    .wr_addr(wr_addr),
    .wr_data(wr_data),
    .flush_req(flush_req),
    .flush_ack(flush_ack),
    .redirect_valid(redirect_valid),
    .redirect_pc(redirect_pc),
    .redirect_ready(redirect_ready),
    .instret(instret)
  );

  always #5 clk_core = ~clk_core;

  // unit model: ack registers req, each bit after its own delay
  always @(posedge clk_core or negedge rst_core_n) begin
    if (!rst_core_n) begin
      flush_ack <= '1;
      ack_cnt   <= 0;
    end else if (!flush_req) begin
      ack_cnt <= 0;
      if (!hold_acks) flush_ack <= '0;
    end else begin
      ack_cnt <= ack_cnt + 1;
      for (int i = 0; i < NA; i++)
        flush_ack[i] <= (ack_cnt + 1 >= dly[i]);
    end
  end

  task automatic chk(input string nm,
                     input logic [63:0] got,
                     input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h", nm, got, exp);
    end
  endtask

  function automatic commit_data_t mk(
    input logic [31:0] npc, input logic jmp,
    input logic trp, input logic wb,
    input logic [4:0] rd, input logic [31:0] val);
    commit_data_t c;
    c.pc        = 32'h1000;
    c.next_pc   = npc;
    c.jump      = jmp;
    c.trap      = trp;
    c.writeback = wb;
    c.rd        = rd;
    c.rd_value  = val;
    return c;
  endfunction

  // returns #1 after the accepting edge
  task automatic issue(input commit_data_t c);
    int n = 0;
    valid_i     = 1'b1;
    commit_data = c;
    while (!ready_o && n < 100) begin
      @(posedge clk_core); #1;
      n++;
    end
    if (!ready_o) begin
      checks++; errs++;
      $display("FAIL issue_timeout: ready_o=%0b expected 1", ready_o);
    end else begin
      if (!c.trap && c.writeback && c.rd != 0)
        wb_q.push_back({c.rd, c.rd_value});
      if (c.trap) rd_q.push_back(TV);
      else if (c.jump) rd_q.push_back(c.next_pc);
      if (!c.trap) exp_ir = exp_ir + 64'd1;
    end
    @(posedge clk_core); #1;
    valid_i = 1'b0;
  endtask

  task automatic wait_run();
    int n = 0;
    @(negedge clk_core);
    while (!ready_o && n < 100) begin
      @(negedge clk_core);
      n++;
    end
    chk("wait_run_ready", ready_o, 1);
  endtask

  logic        prev_rv = 1'b0;
  logic        prev_rr = 1'b0;
  logic [31:0] prev_pc = '0;

  always @(negedge clk_core) begin
    if (!rst_core_n) begin
      prev_rv = 1'b0;
    end else begin
      if (wr_en) begin
        if (wb_q.size() == 0) begin
          checks++; errs++;
          $display("FAIL wb_extra: wr_addr=%0d none expected", wr_addr);
        end else begin
          logic [36:0] e;
          e = wb_q.pop_front();
          chk("wb_addr", {59'd0, wr_addr}, {59'd0, e[36:32]});
          chk("wb_data", {32'd0, wr_data}, {32'd0, e[31:0]});
        end
      end
      if (prev_rv && !prev_rr) begin
        chk("redir_hold_v", {63'd0, redirect_valid}, 1);
        chk("redir_hold_pc", {32'd0, redirect_pc}, {32'd0, prev_pc});
      end
      if (redirect_valid && redirect_ready) begin
        if (rd_q.size() == 0) begin
          checks++; errs++;
          $display("FAIL redir_extra: pc=%0h none expected", redirect_pc);
        end else begin
          logic [31:0] e;
          e = rd_q.pop_front();
          chk("redir_pc", {32'd0, redirect_pc}, {32'd0, e});
        end
      end
      prev_rv = redirect_valid;
      prev_rr = redirect_ready;
      prev_pc = redirect_pc;
    end
  end

  initial begin
    // reset
    repeat (3) @(posedge clk_core);
    @(negedge clk_core);
    chk("rst_ready", {63'd0, ready_o}, 0);
    @(posedge clk_core); #1;
    rst_core_n = 1'b1;
    @(posedge clk_core);
    @(negedge clk_core);
    chk("post_rst_ready", {63'd0, ready_o}, 1);
    chk("post_rst_flush", {63'd0, flush_req}, 0);
    chk("post_rst_wr_en", {63'd0, wr_en}, 0);
    chk("post_rst_wr_addr", {59'd0, wr_addr}, 0);
    chk("post_rst_wr_data", {32'd0, wr_data}, 0);
    chk("post_rst_rv", {63'd0, redirect_valid}, 0);
    chk("post_rst_rpc", {32'd0, redirect_pc}, 0);
    chk("post_rst_instret", instret, 0);

    // stream of four writebacks
    @(posedge clk_core); #1;
    for (int i = 1; i <= 4; i++)
      issue(mk(32'h0, 1'b0, 1'b0, 1'b1, 5'(i), 32'(i * 32'h11)));
    chk("stream_instret", instret, exp_ir);
    chk("stream_instret4", instret, 64'd4);

    // rd=0 never writes
    issue(mk(32'h0, 1'b0, 1'b0, 1'b1, 5'd0, 32'hDEAD));
    chk("rd0_instret", instret, 64'd5);
    @(negedge clk_core);
    chk("rd0_no_wr", {63'd0, wr_en}, 0);

    // jump with staggered acks and a slow fetch
    dly = '{1, 2, 3, 4};
    redirect_ready = 1'b0;
    issue(mk(32'h8000_0040, 1'b1, 1'b0, 1'b1, 5'd1, 32'hAA));
    chk("jmp_instret", instret, exp_ir);
    for (int k = 1; k <= 8; k++) begin
      @(negedge clk_core);
      chk($sformatf("jmp_flush_c%0d", k), {63'd0, flush_req}, 1);
      chk($sformatf("jmp_ready_c%0d", k), {63'd0, ready_o}, 0);
      chk($sformatf("jmp_rv_c%0d", k), {63'd0, redirect_valid},
          {63'd0, (k >= 6)});
      if (k == 7) begin
        @(posedge clk_core); #1;
        redirect_ready = 1'b1;
      end
    end
    @(negedge clk_core);
    chk("jmp_done_flush", {63'd0, flush_req}, 0);
    chk("jmp_done_rv", {63'd0, redirect_valid}, 0);
    chk("jmp_done_ready", {63'd0, ready_o}, 1);
    dly = '{1, 1, 1, 1};

    // trap overrides jump, no writeback, no count
    @(posedge clk_core); #1;
    issue(mk(32'h0000_1234, 1'b1, 1'b1, 1'b1, 5'd5, 32'h55));
    chk("trap_instret", instret, exp_ir);
    wait_run();
    chk("trap_instret_after", instret, 64'd6);

    // back-to-back flush with stale acks held high
    @(posedge clk_core); #1;
    issue(mk(32'h8000_0100, 1'b1, 1'b0, 1'b0, 5'd0, 32'h0));
    begin
      int n = 0;
      while (!redirect_valid && n < 100) begin
        @(negedge clk_core);
        n++;
      end
      chk("b2b_first_rv", {63'd0, redirect_valid}, 1);
    end
    hold_acks = 1'b1;
    @(posedge clk_core); #1;
    valid_i     = 1'b1;
    commit_data = mk(32'h8000_0200, 1'b1, 1'b0, 1'b0, 5'd0, 32'h0);
    chk("b2b_first_run_ready", {63'd0, ready_o}, 1);
    rd_q.push_back(32'h8000_0200);
    exp_ir = exp_ir + 64'd1;
    @(posedge clk_core); #1;
    valid_i   = 1'b0;
    hold_acks = 1'b0;
    for (int k = 1; k <= 3; k++) begin
      @(negedge clk_core);
      chk($sformatf("b2b_flush_c%0d", k), {63'd0, flush_req}, 1);
      chk($sformatf("b2b_rv_c%0d", k), {63'd0, redirect_valid},
          {63'd0, (k == 3)});
    end
    chk("b2b_pc", {32'd0, redirect_pc}, 64'h8000_0200);
    wait_run();
    chk("b2b_instret", instret, exp_ir);

    // reset while flushing
    @(posedge clk_core); #1;
    issue(mk(32'h8000_0300, 1'b1, 1'b0, 1'b0, 5'd0, 32'h0));
    @(negedge clk_core);
    chk("mid_flush_req", {63'd0, flush_req}, 1);
    #1;
    rst_core_n = 1'b0;
    #1;
    chk("mid_rst_flush", {63'd0, flush_req}, 0);
    chk("mid_rst_ready", {63'd0, ready_o}, 0);
    chk("mid_rst_rv", {63'd0, redirect_valid}, 0);
    chk("mid_rst_instret", instret, 0);
    rd_q.delete();
    exp_ir = '0;
    @(posedge clk_core); #1;
    rst_core_n = 1'b1;
    wait_run();
    chk("mid_rst_run_flush", {63'd0, flush_req}, 0);
    @(posedge clk_core); #1;
    issue(mk(32'h0, 1'b0, 1'b0, 1'b1, 5'd7, 32'h77));
    chk("mid_rst_instret1", instret, 64'd1);
    repeat (3) @(negedge clk_core);

    chk("wb_q_empty", 64'(wb_q.size()), 0);
    chk("rd_q_empty", 64'(rd_q.size()), 0);

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
